// File: rtl/brch_pred_update_ctrl.sv
// Update sequencer for the GHR-indexed branch predictor: sweeps the PHT to weakly
// not-taken, tracks IF predictions until they resolve in ID, and issues updates and flushes.
module brch_pred_update_ctrl #(
    parameter int PHT_ADDR_W = 5,
    parameter int QDEPTH     = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  brch_instr_detectd_IF,
    input  logic                  predict_br_taken,
    input  logic                  brch_instr_detectd_ID,
    input  logic                  brch_hazard_stall,
    input  logic                  actual_brch_result,
    input  logic                  pht_reinit_req,
    output logic                  init_busy,
    output logic                  pht_init_wr,
    output logic [PHT_ADDR_W-1:0] pht_init_addr,
    output logic [1:0]            pht_init_data,
    output logic                  upd_br_pred_state,
    output logic                  upd_actual_result,
    output logic                  mispredict_flush,
    output logic                  q_overflow_err,
    output logic                  q_underflow_err,
    output logic [CNT_W-1:0]      br_resolved_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);

    localparam int QPTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int QCNT_W = $clog2(QDEPTH) + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [PHT_ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [QCNT_W-1:0]     Q_FULL_CNT = QCNT_W'(QDEPTH);

    logic [0:0]            state_reg, state_next;
    logic [PHT_ADDR_W-1:0] addr_reg, addr_next;

    logic                  q_mem [QDEPTH];
    logic [QPTR_W-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [QCNT_W-1:0]     q_cnt_reg;

    logic                  flush_reg, ovf_reg, unf_reg;
    logic [CNT_W-1:0]      br_cnt_reg, mp_cnt_reg;

    logic in_run, push, resolve, pop, push_ok, push_drop;
    logic q_empty, q_full, predicted, mispredict, enter_init;

    always_comb begin
        in_run     = (state_reg == ST_RUN);
        push       = in_run & brch_instr_detectd_IF & ~brch_hazard_stall & ~flush_reg;
        resolve    = in_run & brch_instr_detectd_ID & ~brch_hazard_stall;
        q_empty    = (q_cnt_reg == '0);
        q_full     = (q_cnt_reg == Q_FULL_CNT);
        pop        = resolve & ~q_empty;
        // An empty queue resolves as if predicted not-taken.
        predicted  = q_empty ? 1'b0 : q_mem[rd_ptr_reg];
        mispredict = resolve & (predicted != actual_brch_result);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push_ok    = push & (~q_full | pop);
        push_drop  = push & q_full & ~pop;
        enter_init = in_run & pht_reinit_req;
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        if (state_reg == ST_INIT) begin
            addr_next = addr_reg + PHT_ADDR_W'(1);
            if (addr_reg == ADDR_LAST) begin
                state_next = ST_RUN;
            end
        end else if (pht_reinit_req) begin
            state_next = ST_INIT;
            addr_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_mem[wr_ptr_reg] <= predict_br_taken;
        end
    end

    // The cycle after a mispredict drops all queued entries: they belong to the wrong path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            q_cnt_reg  <= '0;
        end else if (enter_init || flush_reg) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            q_cnt_reg  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + QPTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + QPTR_W'(1);
            end
            q_cnt_reg <= q_cnt_reg + QCNT_W'(push_ok) - QCNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (enter_init) begin
            flush_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            flush_reg <= mispredict;
            ovf_reg   <= ovf_reg | push_drop;
            unf_reg   <= unf_reg | (resolve & q_empty);
        end
    end

    // Statistics survive a PHT re-initialisation; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_reg <= '0;
            mp_cnt_reg <= '0;
        end else begin
            if (resolve && (br_cnt_reg != '1)) begin
                br_cnt_reg <= br_cnt_reg + CNT_W'(1);
            end
            if (mispredict && (mp_cnt_reg != '1)) begin
                mp_cnt_reg <= mp_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign init_busy         = (state_reg == ST_INIT);
    assign pht_init_wr       = (state_reg == ST_INIT);
    assign pht_init_addr     = addr_reg;
    assign pht_init_data     = 2'b01;
    assign upd_br_pred_state = resolve;
    assign upd_actual_result = actual_brch_result;
    assign mispredict_flush  = flush_reg;
    assign q_overflow_err    = ovf_reg;
    assign q_underflow_err   = unf_reg;
    assign br_resolved_cnt   = br_cnt_reg;
    assign mispredict_cnt    = mp_cnt_reg;

endmodule

// File: tb/tb_brch_pred_update_ctrl.sv
// Directed, table-driven bench for brch_pred_update_ctrl: PHT sweep, queue tracking,
// flush/overflow/underflow corners, stall, re-init and mid-sweep reset.
module tb_brch_pred_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        brch_instr_detectd_IF, predict_br_taken, brch_instr_detectd_ID;
    logic        brch_hazard_stall, actual_brch_result, pht_reinit_req;
    logic        init_busy, pht_init_wr;
    logic [4:0]  pht_init_addr;
    logic [1:0]  pht_init_data;
    logic        upd_br_pred_state, upd_actual_result, mispredict_flush;
    logic        q_overflow_err, q_underflow_err;
    logic [15:0] br_resolved_cnt, mispredict_cnt;

    int n_pass = 0;
    int n_checks = 0;

    brch_pred_update_ctrl #(.PHT_ADDR_W(5), .QDEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .brch_instr_detectd_IF(brch_instr_detectd_IF), .predict_br_taken(predict_br_taken),
        .brch_instr_detectd_ID(brch_instr_detectd_ID), .brch_hazard_stall(brch_hazard_stall),
        .actual_brch_result(actual_brch_result), .pht_reinit_req(pht_reinit_req),
        .init_busy(init_busy), .pht_init_wr(pht_init_wr), .pht_init_addr(pht_init_addr),
        .pht_init_data(pht_init_data), .upd_br_pred_state(upd_br_pred_state),
        .upd_actual_result(upd_actual_result), .mispredict_flush(mispredict_flush),
        .q_overflow_err(q_overflow_err), .q_underflow_err(q_underflow_err),
        .br_resolved_cnt(br_resolved_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic f_if, pred, f_id, stall, act;
        logic e_upd, e_flush, e_ovf, e_unf;
        int   e_br, e_mp;
    } vec_t;

    vec_t tbl_a [26];
    vec_t tbl_b [8];

    function automatic vec_t mk(input logic f_if, input logic pred, input logic f_id,
                                input logic stall, input logic act, input logic e_upd,
                                input logic e_flush, input logic e_ovf, input logic e_unf,
                                input int e_br, input int e_mp);
        vec_t v;
        v.f_if = f_if; v.pred = pred; v.f_id = f_id; v.stall = stall; v.act = act;
        v.e_upd = e_upd; v.e_flush = e_flush; v.e_ovf = e_ovf; v.e_unf = e_unf;
        v.e_br = e_br; v.e_mp = e_mp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive_idle();
        brch_instr_detectd_IF = 0; predict_br_taken = 0; brch_instr_detectd_ID = 0;
        brch_hazard_stall = 0; actual_brch_result = 0; pht_reinit_req = 0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive_idle();
        brch_instr_detectd_IF = v.f_if; predict_br_taken = v.pred;
        brch_instr_detectd_ID = v.f_id; brch_hazard_stall = v.stall;
        actual_brch_result = v.act;
        #1;
        chk({tag, ".upd"},   32'(upd_br_pred_state), 32'(v.e_upd));
        chk({tag, ".res"},   32'(upd_actual_result), 32'(v.act));
        chk({tag, ".flush"}, 32'(mispredict_flush),  32'(v.e_flush));
        chk({tag, ".ovf"},   32'(q_overflow_err),    32'(v.e_ovf));
        chk({tag, ".unf"},   32'(q_underflow_err),   32'(v.e_unf));
        chk({tag, ".br"},    32'(br_resolved_cnt),   32'(v.e_br));
        chk({tag, ".mp"},    32'(mispredict_cnt),    32'(v.e_mp));
        chk({tag, ".busy"},  32'(init_busy),         32'd0);
        $display("%s: if=%0b p=%0b id=%0b st=%0b a=%0b -> upd=%0b fl=%0b ovf=%0b unf=%0b br=%0d mp=%0d",
                 tag, v.f_if, v.pred, v.f_id, v.stall, v.act, upd_br_pred_state,
                 mispredict_flush, q_overflow_err, q_underflow_err, br_resolved_cnt, mispredict_cnt);
    endtask

    task automatic sweep(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_idle();
            #1;
            chk($sformatf("%s.busy%0d", tag, i), 32'(init_busy), 32'd1);
            chk($sformatf("%s.wr%0d", tag, i), 32'(pht_init_wr), 32'd1);
            chk($sformatf("%s.addr%0d", tag, i), 32'(pht_init_addr), 32'(i));
            chk($sformatf("%s.data%0d", tag, i), 32'(pht_init_data), 32'd1);
        end
        $display("%s: swept %0d addresses", tag, n);
    endtask

    task automatic run_check(input int e_br, input int e_mp, input string tag);
        @(negedge clk);
        drive_idle();
        #1;
        chk({tag, ".busy"},  32'(init_busy),        32'd0);
        chk({tag, ".wr"},    32'(pht_init_wr),      32'd0);
        chk({tag, ".flush"}, 32'(mispredict_flush), 32'd0);
        chk({tag, ".ovf"},   32'(q_overflow_err),   32'd0);
        chk({tag, ".unf"},   32'(q_underflow_err),  32'd0);
        chk({tag, ".br"},    32'(br_resolved_cnt),  32'(e_br));
        chk({tag, ".mp"},    32'(mispredict_cnt),   32'(e_mp));
        $display("%s: run busy=%0b br=%0d mp=%0d", tag, init_busy, br_resolved_cnt, mispredict_cnt);
    endtask

    initial begin
        //                 if p  id st a   upd fl ovf unf br mp
        tbl_a[0]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl_a[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl_a[2]  = mk(0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
        tbl_a[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl_a[4]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl_a[5]  = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl_a[6]  = mk(0, 0, 1, 0, 1,  1, 0, 0, 0, 1, 0);
        tbl_a[7]  = mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 2, 1);
        tbl_a[8]  = mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 2, 1);
        tbl_a[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 3, 1);
        tbl_a[10] = mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 3, 1);
        tbl_a[11] = mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 3, 1);
        tbl_a[12] = mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 1);
        tbl_a[13] = mk(1, 1, 1, 0, 1,  1, 0, 1, 1, 3, 1);
        tbl_a[14] = mk(0, 0, 1, 0, 1,  1, 0, 1, 1, 4, 1);
        tbl_a[15] = mk(0, 0, 1, 0, 1,  1, 0, 1, 1, 5, 1);
        tbl_a[16] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 6, 1);
        for (int i = 17; i <= 21; i++) tbl_a[i] = mk(1, 1, 1, 1, 0,  0, 0, 1, 1, 6, 1);
        tbl_a[22] = mk(0, 0, 1, 0, 1,  1, 0, 1, 1, 6, 1);
        tbl_a[23] = mk(0, 0, 0, 0, 0,  0, 1, 1, 1, 7, 2);
        tbl_a[24] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 7, 2);
        tbl_a[25] = mk(1, 1, 0, 0, 0,  0, 0, 1, 1, 7, 2);

        // Resolve during the flush cycle, with a suppressed push, then an underflow.
        tbl_b[0] = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl_b[1] = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl_b[2] = mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl_b[3] = mk(1, 0, 1, 0, 1,  1, 1, 0, 0, 1, 1);
        tbl_b[4] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1);
        tbl_b[5] = mk(0, 0, 1, 0, 1,  1, 0, 0, 0, 2, 1);
        tbl_b[6] = mk(0, 0, 0, 0, 0,  0, 1, 0, 1, 3, 2);
        tbl_b[7] = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2);

        rst_n = 0;
        drive_idle();
        #1;
        chk("rst.busy",  32'(init_busy),         32'd1);
        chk("rst.wr",    32'(pht_init_wr),       32'd1);
        chk("rst.addr",  32'(pht_init_addr),     32'd0);
        chk("rst.upd",   32'(upd_br_pred_state), 32'd0);
        chk("rst.flush", 32'(mispredict_flush),  32'd0);
        chk("rst.ovf",   32'(q_overflow_err),    32'd0);
        chk("rst.unf",   32'(q_underflow_err),   32'd0);
        chk("rst.br",    32'(br_resolved_cnt),   32'd0);
        chk("rst.mp",    32'(mispredict_cnt),    32'd0);
        $display("reset: busy=%0b addr=%0d", init_busy, pht_init_addr);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        sweep(32, "init");
        run_check(0, 0, "run0");
        for (int i = 0; i < 26; i++) apply_vec(tbl_a[i], $sformatf("a%0d", i));

        // Re-init with one queued entry: queue and flags clear, counters stay.
        @(negedge clk);
        drive_idle();
        pht_reinit_req = 1;
        #1;
        chk("reinit.busy_before", 32'(init_busy), 32'd0);
        $display("reinit: request issued");
        sweep(32, "reinit");
        run_check(7, 2, "run1");
        apply_vec(mk(0, 0, 1, 0, 0,  1, 0, 0, 0, 7, 2), "post_reinit_res");
        apply_vec(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 8, 2), "post_reinit_idle");

        // Second re-init, aborted by reset at address 17.
        @(negedge clk);
        drive_idle();
        pht_reinit_req = 1;
        sweep(17, "abort");
        @(negedge clk);
        drive_idle();
        #1;
        chk("abort.addr17", 32'(pht_init_addr), 32'd17);
        rst_n = 0;
        #1;
        chk("abort.addr0", 32'(pht_init_addr),   32'd0);
        chk("abort.busy",  32'(init_busy),       32'd1);
        chk("abort.br",    32'(br_resolved_cnt), 32'd0);
        chk("abort.mp",    32'(mispredict_cnt),  32'd0);
        $display("abort: reset at addr 17 -> addr=%0d", pht_init_addr);
        @(posedge clk);
        #2 rst_n = 1;
        sweep(32, "restart");
        run_check(0, 0, "run2");
        for (int i = 0; i < 8; i++) apply_vec(tbl_b[i], $sformatf("b%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brch_pred_update_ctrl.md
# brch_pred_update_ctrl

Sequencing controller for the correlational (GHR-indexed) branch predictor. It initialises the 32-entry pattern history table after reset or on request, and tracks each IF-stage prediction in a small in-order queue until the branch resolves in ID. At resolution it issues the single-cycle GHR/PHT update and flags mispredictions to the pipeline. It also keeps saturating branch and mispredict statistics counters.

## Interface
- PHT_ADDR_W, 5: PHT index width; the PHT has 2^PHT_ADDR_W entries.
- QDEPTH, 2: depth of the prediction-tracking queue (power of two, ≥2).
- CNT_W, 16: width of the statistics counters.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- brch_instr_detectd_IF  in  1  branch present in IF.
- predict_br_taken  in  1  predictor output for the IF branch.
- brch_instr_detectd_ID  in  1  branch resolving in ID.
- brch_hazard_stall  in  1  pipeline stall; blocks both push and resolve.
- actual_brch_result  in  1  resolved direction (1 = taken).
- pht_reinit_req  in  1  one-cycle pulse requesting PHT re-initialisation.
- init_busy  out  1  INIT sweep in progress; the pipeline must stall.
- pht_init_wr  out  1  PHT init write strobe.
- pht_init_addr  out  PHT_ADDR_W  PHT init write address.
- pht_init_data  out  2  init counter value, constant 2'b01 (weakly not-taken).
- upd_br_pred_state  out  1  GHR/PHT update strobe.
- upd_actual_result  out  1  direction to shift into the GHR and train the PHT.
- mispredict_flush  out  1  one-cycle flush pulse.
- q_overflow_err  out  1  sticky: a push was dropped because the queue was full.
- q_underflow_err  out  1  sticky: a resolve arrived with the queue empty.
- br_resolved_cnt  out  CNT_W  saturating count of resolved branches.
- mispredict_cnt  out  CNT_W  saturating count of mispredicted branches.

## Operation
- FSM states: INIT, RUN. Reset enters INIT with the address counter at 0.
- INIT behaviour:
  - pht_init_wr = 1, pht_init_addr = counter, counter increments every cycle.
  - After the write to address 2^PHT_ADDR_W−1, the FSM moves to RUN.
  - init_busy = (state == INIT).
  - On entry to INIT, the queue, both error flags and mispredict_flush are cleared. Statistics counters are not cleared.
- In RUN, pht_reinit_req moves the FSM to INIT on the next edge with the counter at 0. The request is ignored while in INIT.
- push = RUN & brch_instr_detectd_IF & !brch_hazard_stall & !mispredict_flush. It enqueues predict_br_taken.
- resolve = RUN & brch_instr_detectd_ID & !brch_hazard_stall. It dequeues the head entry.
  - If the queue is empty, the predicted value is taken as 0 and q_underflow_err is set.
- upd_br_pred_state = resolve and upd_actual_result = actual_brch_result. Both are combinational, in the same cycle as resolve.
- Mispredict is (predicted ≠ actual_brch_result) on a resolve. It registers mispredict_flush = 1 for exactly the next cycle.
  - In that next cycle the queue is cleared, because its entries are wrong-path.
  - Pushes are suppressed in that cycle.
  - A resolve in that same cycle is still processed: update issued, treated as an underflow only if the queue was empty before the clear.
- Push to a full queue:
  - With a simultaneous resolve: pop, then push; no overflow.
  - Without a resolve: the push is dropped and q_overflow_err is set.
- Each resolve increments br_resolved_cnt; each mispredict increments mispredict_cnt. Both saturate at all-ones and never wrap.
- Queue pointers are QDEPTH-modulo and wrap silently; an occupancy count of log2(QDEPTH)+1 bits distinguishes full from empty.

## Timing
- Reset values:
  - init_busy = 1, pht_init_wr = 1, pht_init_addr = 0.
  - upd_br_pred_state = 0, mispredict_flush = 0.
  - Both error flags = 0, both counters = 0, queue empty.
- INIT lasts exactly 2^PHT_ADDR_W cycles (32 by default). The first RUN cycle follows directly.
- Update latency is 0 cycles from resolve. Flush latency is 1 cycle from resolve, 1 cycle wide.
- Counters and error flags become visible 1 cycle after the causing event.
- A stall freezes the queue and suppresses updates; the FSM and the INIT counter keep running.
- Asserting rst_n low mid-INIT or mid-RUN aborts immediately; the sweep restarts at address 0 on release.

## Test plan
- Reset release:
  - init_busy is high for 32 cycles.
  - pht_init_addr steps 0..31 with data 2'b01.
  - Cycle 33 is RUN, with both counters 0.
- Correct prediction: push pred=1, resolve 2 cycles later with actual=1 → upd_br_pred_state pulse, upd_actual_result = 1, no flush, br_resolved_cnt = 1, mispredict_cnt = 0.
- Mispredict:
  - Push pred=0, push pred=1, resolve actual=1.
  - Flush pulses for 1 cycle and the queue empties; a second resolve then sets q_underflow_err.
  - mispredict_cnt = 1.
- Full queue (QDEPTH=2):
  - Third push with no resolve sets q_overflow_err.
  - Third push with a simultaneous resolve sets no error and leaves occupancy at 2.
- Stall: hold brch_hazard_stall high with IF/ID branch flags high for 5 cycles → no push, no update, counters unchanged.
- pht_reinit_req in RUN with 1 queued entry → 32-cycle sweep runs, queue empties, counters are retained. Asserting rst_n low at sweep address 17 → sweep restarts at 0.
